seq_divider_16: RTL and testbench

Sequential restoring unsigned integer divider. It sits directly upstream of the 7-segment display encoder in the 16-bit sequential-division design. It accepts a dividend and divisor on a start pulse and computes one quotient bit per clock. It presents a stable 16-bit quotient and remainder that the display stage encodes nibble-by-nibble.

---
 rtl/seq_divider_16.sv | 98 +++++++++
 tb/tb_seq_divider_16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16.sv
// Sequential restoring unsigned divider: one quotient bit per clock.
// Results are registered and change only on entry to DONE, so the display never sees partial values.
module seq_divider_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, prem_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   shf_d;
  logic             qbit_d;
  logic [WIDTH-1:0] prem_d, dvd_d;

  // Compare at WIDTH+1 bits; the difference always fits in WIDTH bits when taken.
  always_comb begin
    shf_d  = {prem_q, dvd_q[WIDTH-1]};
    qbit_d = (shf_d >= {1'b0, dsr_q});
    prem_d = qbit_d ? (shf_d[WIDTH-1:0] - dsr_q) : shf_d[WIDTH-1:0];
    dvd_d  = {dvd_q[WIDTH-2:0], qbit_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dsr_q  <= divisor;
            prem_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_q  <= dvd_d;
            rem_q   <= prem_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_16.sv
// Scoreboard bench for seq_divider_16: expected results and done-cycle queued at start,
// popped and compared when done strobes.
module tb_seq_divider_16;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0, cyc = 0, ndone = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each done pulse must match the oldest queued expectation, including the cycle it appears.
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [15:0] q, input logic [15:0] r, input logic z, input int k);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.cyc = z ? k : k + 16;
    sbq.push_back(e);
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (ndone < target && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (ndone < target) chk("done_timeout", 32'(ndone), 32'(target));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] q, input logic [15:0] r, input logic z);
    int target;
    target = ndone + 1;
    dividend = a; divisor = b; start = 1'b1;
    push(q, r, z, cyc + 1);
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_dones(target);
    @(negedge clk);
  endtask

  int k, target;

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 100/7 with busy check the cycle after the start edge
    target = ndone + 1;
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    push(16'd14, 16'd2, 1'b0, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_dones(target);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);

    run(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    run(16'h0003, 16'h000A, 16'h0000, 16'h0003, 1'b0);
    run(16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1'b1);
    run(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    run(16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
    run(16'd77, 16'd77, 16'd1, 16'd0, 1'b0);

    // 1000/10 with ignored start pulses at CALC cycles 5 and 16; previous result must hold
    target = ndone + 1;
    k = cyc + 1;
    dividend = 16'd1000; divisor = 16'd10; start = 1'b1;
    push(16'd100, 16'd0, 1'b0, k);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 15) begin
      if (cyc == k + 4) begin
        start = 1'b1; dividend = 16'd7; divisor = 16'd2;
      end else begin
        start = 1'b0;
      end
      if (cyc == k + 8) chk("hold_quot", 32'(quotient), 32'd1);
      @(negedge clk);
    end
    chk("hold_rem", 32'(remainder), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dones(target);
    repeat (25) @(negedge clk);
    chk("no_extra_done", 32'(ndone), 32'(target));

    // Abort mid-CALC with async reset
    k = cyc + 1;
    dividend = 16'd200; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quot", 32'(quotient), 32'd0);
    chk("abort_rem", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    target = ndone;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(ndone), 32'(target));
    run(16'd50, 16'd6, 16'd8, 16'd2, 1'b0);

    // Start held high: back-to-back divisions every 18 cycles
    target = ndone + 3;
    k = cyc + 1;
    dividend = 16'hABCD; divisor = 16'h0010; start = 1'b1;
    for (int i = 0; i < 3; i++) push(16'h0ABC, 16'h000D, 1'b0, k + 18 * i);
    while (cyc < k + 36) @(negedge clk);
    start = 1'b0;
    wait_dones(target);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
